// File: rtl/data_cache_pkg.sv
// Shared types and field widths for the direct-mapped write-back data cache.
package data_cache_pkg;
  localparam int LINE_SIZE = 16;
  localparam int TAG_W     = 24;
  localparam int INDEX_W   = 4;
  localparam int OFFSET_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    ALLOC_REQ,
    ALLOC_WAIT
  } state_t;
endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: combinational read, single synchronous write port.
module cache_array
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int LINE_W   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  input  logic               wr_dirty
);
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   line_q [NUM_SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = line_q[rd_index];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Payload is not cleared; gating on reset keeps an abandoned refill from landing.
  always_ff @(posedge clk) begin
    if (wr_en && reset) begin
      tag_q[wr_index]  <= wr_tag;
      line_q[wr_index] <= wr_line;
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a blocking miss FSM.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 16,
  parameter int WORD      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [WORD-1:0]        din,
  output logic                   is_ready,
  output logic                   is_output_valid,
  output logic [WORD-1:0]        dout,
  output logic                   is_hit,
  output logic                   dm_is_input_valid,
  output logic [31:0]            dm_addr,
  output logic                   dm_read,
  output logic                   dm_write,
  output logic [8*LINE_SIZE-1:0] dm_din,
  input  logic                   dm_is_output_valid,
  input  logic [8*LINE_SIZE-1:0] dm_dout,
  input  logic                   dm_ready,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);
  localparam int LINE_W = 8 * LINE_SIZE;

  state_t state;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [1:0]         req_word;
  logic               unused_addr_lsb;

  assign req_tag         = addr[31:8];
  assign req_index       = addr[7:4];
  assign req_word        = addr[OFFSET_W-1:2];
  assign unused_addr_lsb = ^addr[1:0];

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              wr_en, wr_dirty;
  logic [LINE_W-1:0] wr_line;

  cache_array #(
    .NUM_SETS (NUM_SETS),
    .LINE_W   (LINE_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_line  (wr_line),
    .wr_dirty (wr_dirty)
  );

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel,
                                                   input logic [WORD-1:0]   data);
    logic [LINE_W-1:0] res;
    res = line;
    res[int'(sel)*WORD +: WORD] = data;
    return res;
  endfunction

  logic req_any, is_store;

  // A request carrying both read and write is a store.
  assign req_any         = is_input_valid & (mem_read | mem_write);
  assign is_store        = mem_write;
  assign is_ready        = (state == IDLE);
  assign is_hit          = is_ready & req_any & rd_valid & (rd_tag == req_tag);
  assign is_output_valid = is_hit & ~is_store;
  assign dout            = is_output_valid ? rd_line[int'(req_word)*WORD +: WORD] : '0;

  always_comb begin
    wr_en    = 1'b0;
    wr_dirty = 1'b0;
    wr_line  = rd_line;
    if (is_hit && is_store) begin
      wr_en    = 1'b1;
      wr_dirty = 1'b1;
      wr_line  = merge_word(rd_line, req_word, din);
    end else if (state == ALLOC_WAIT && dm_is_output_valid) begin
      wr_en   = 1'b1;
      wr_line = dm_dout;
    end
  end

  // Memory-side outputs are registered and set on entry to each request state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      hit_count         <= '0;
      miss_count        <= '0;
      dm_is_input_valid <= 1'b0;
      dm_read           <= 1'b0;
      dm_write          <= 1'b0;
      dm_addr           <= '0;
      dm_din            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_hit) begin
            hit_count <= hit_count + 32'd1;
          end else if (req_any) begin
            miss_count        <= miss_count + 32'd1;
            dm_is_input_valid <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state    <= WB_REQ;
              dm_write <= 1'b1;
              dm_addr  <= {4'b0, rd_tag, req_index};
              dm_din   <= rd_line;
            end else begin
              state   <= ALLOC_REQ;
              dm_read <= 1'b1;
              dm_addr <= {4'b0, addr[31:4]};
            end
          end
        end
        WB_REQ: begin
          if (dm_ready) begin
            state             <= WB_WAIT;
            dm_is_input_valid <= 1'b0;
            dm_write          <= 1'b0;
            dm_addr           <= '0;
            dm_din            <= '0;
          end
        end
        WB_WAIT: begin
          if (dm_ready) begin
            state             <= ALLOC_REQ;
            dm_is_input_valid <= 1'b1;
            dm_read           <= 1'b1;
            dm_addr           <= {4'b0, addr[31:4]};
          end
        end
        ALLOC_REQ: begin
          if (dm_ready) begin
            state             <= ALLOC_WAIT;
            dm_is_input_valid <= 1'b0;
            dm_read           <= 1'b0;
            dm_addr           <= '0;
          end
        end
        ALLOC_WAIT: begin
          if (dm_is_output_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache against a flat-memory golden model and a latency-modelled backing store.
module tb_data_cache;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  din = '0;
  logic         is_ready, is_output_valid, is_hit;
  logic [31:0]  dout;
  logic         dm_is_input_valid, dm_read, dm_write;
  logic [31:0]  dm_addr;
  logic [127:0] dm_din;
  logic         dm_is_output_valid = 1'b0;
  logic [127:0] dm_dout = '0;
  logic         dm_ready = 1'b1;
  logic [31:0]  hit_count, miss_count;

  data_cache dut (
    .clk                (clk),
    .reset              (reset),
    .is_input_valid     (is_input_valid),
    .addr               (addr),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .din                (din),
    .is_ready           (is_ready),
    .is_output_valid    (is_output_valid),
    .dout               (dout),
    .is_hit             (is_hit),
    .dm_is_input_valid  (dm_is_input_valid),
    .dm_addr            (dm_addr),
    .dm_read            (dm_read),
    .dm_write           (dm_write),
    .dm_din             (dm_din),
    .dm_is_output_valid (dm_is_output_valid),
    .dm_dout            (dm_dout),
    .dm_ready           (dm_ready),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden CPU-visible memory: every word starts with a value derived from its address.
  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {wa[15:0], ~wa[15:0]};
  endfunction

  logic [31:0]  gold [logic [29:0]];
  logic [127:0] mem  [logic [27:0]];

  function automatic logic [31:0] gword(input logic [29:0] wa);
    if (gold.exists(wa)) return gold[wa];
    return init_word(wa);
  endfunction

  function automatic logic [127:0] gline(input logic [27:0] blk);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = gword({blk, i[1:0]});
    return l;
  endfunction

  function automatic logic [127:0] mline(input logic [27:0] blk);
    logic [127:0] l;
    if (mem.exists(blk)) return mem[blk];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = init_word({blk, i[1:0]});
    return l;
  endfunction

  // Backing memory: accepts one request when ready, stays busy mem_delay cycles.
  int           mem_delay = 2;
  bit           hold_ready = 1'b0;
  bit           rand_stall = 1'b0;
  int           busy = 0;
  bit           pend = 1'b0;
  logic [27:0]  pend_blk = '0;
  int           rd_cnt = 0, wr_cnt = 0;
  logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_line = '0;

  always @(posedge clk) begin
    logic         acc_rd, acc_wr;
    logic [31:0]  a;
    logic [127:0] wl;
    acc_rd = reset && dm_ready && dm_is_input_valid && dm_read;
    acc_wr = reset && dm_ready && dm_is_input_valid && dm_write;
    a  = dm_addr;
    wl = dm_din;
    #1;
    dm_is_output_valid = 1'b0;
    dm_dout = '0;
    if (!reset) begin
      busy = 0;
      pend = 1'b0;
      dm_ready = 1'b1;
    end else begin
      if (acc_wr) begin
        check("wb_line_vs_golden", wl, gline(a[27:0]));
        mem[a[27:0]] = wl;
        wr_cnt++;
        last_wr_addr = a;
        last_wr_line = wl;
        busy = mem_delay;
      end else if (acc_rd) begin
        rd_cnt++;
        last_rd_addr = a;
        pend = 1'b1;
        pend_blk = a[27:0];
        busy = mem_delay;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0 && pend) begin
          dm_is_output_valid = 1'b1;
          dm_dout = mline(pend_blk);
          pend = 1'b0;
        end
      end
      dm_ready = (busy == 0) && !hold_ready && !(rand_stall && $urandom_range(0, 3) == 0);
    end
  end

  // Cache presence model: which block each set should hold, and whether it was stored to.
  bit          mvalid [16];
  bit          mdirty [16];
  logic [23:0] mtag   [16];
  int          exp_hits = 0, exp_misses = 0;

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Per-cycle output checks.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      check("dm_rw_exclusive", 128'(dm_read & dm_write), 128'(1'b0));
      if (!is_ready)
        check("busy_cpu_outputs", 128'({is_hit, is_output_valid, dout}), '0);
      else
        check("idle_no_dm_request", 128'(dm_is_input_valid), '0);
      check("output_valid_rule", 128'(is_output_valid), 128'(is_hit & mem_read & ~mem_write));
      if (is_output_valid)
        check("load_data", 128'(dout), 128'(gword(addr[31:2])));
    end
  end

  // Issue one request at a negedge, hold it until it hits, then update the models.
  task automatic do_req(input logic [31:0] a, input bit wr, input bit rd, input logic [31:0] d,
                        output logic [31:0] rdata, output bit missed);
    logic [3:0]  idx;
    logic [23:0] tg;
    bit          exp_hit, exp_wb;
    int          rd0, wr0, cyc;
    idx = a[7:4];
    tg  = a[31:8];
    exp_hit = mvalid[idx] && (mtag[idx] == tg);
    exp_wb  = !exp_hit && mvalid[idx] && mdirty[idx];
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    is_input_valid = 1'b1;
    addr = a;
    mem_read = rd;
    mem_write = wr;
    din = d;
    #1;
    check("first_cycle_hit", 128'(is_hit), 128'(exp_hit));
    missed = !is_hit;
    cyc = 0;
    while (!is_hit && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("request_completes", 128'(is_hit), 128'(1'b1));
    rdata = dout;
    @(posedge clk);
    #1;
    if (wr) gold[a[31:2]] = d;
    mvalid[idx] = 1'b1;
    mtag[idx] = tg;
    if (!exp_hit) mdirty[idx] = 1'b0;
    if (wr) mdirty[idx] = 1'b1;
    exp_hits++;
    if (!exp_hit) exp_misses++;
    check("refill_reads", 128'(rd_cnt - rd0), 128'(exp_hit ? 0 : 1));
    check("writebacks", 128'(wr_cnt - wr0), 128'(exp_wb ? 1 : 0));
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    bit          missed;
    int          cyc;
    clear_model();
    repeat (2) @(negedge clk);
    is_input_valid = 1'b1;
    mem_read = 1'b1;
    addr = 32'h100;
    #1;
    check("reset_ready", 128'(is_ready), 128'(1'b1));
    check("reset_counters", 128'({hit_count, miss_count}), '0);
    check("reset_dm_ctrl", 128'({dm_is_input_valid, dm_read, dm_write, dm_addr}), '0);
    check("reset_dm_din", dm_din, '0);
    check("reset_cpu_outs", 128'({is_hit, is_output_valid, dout}), '0);
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Cold load to 0x100
    do_req(32'h100, 1'b0, 1'b1, '0, rdata, missed);
    check("cold_missed", 128'(missed), 128'(1'b1));
    check("cold_rd_addr", 128'(last_rd_addr), 128'(32'h10));
    check("cold_counts", 128'({hit_count, miss_count}), {64'h0, 32'd1, 32'd1});
    check("cold_data", 128'(rdata), 128'(32'h0040FFBF));

    // Store hit then load hit
    do_req(32'h104, 1'b1, 1'b0, 32'hDEADBEEF, rdata, missed);
    check("store_hit", 128'(missed), '0);
    do_req(32'h104, 1'b0, 1'b1, '0, rdata, missed);
    check("load_hit", 128'(missed), '0);
    check("load_hit_data", 128'(rdata), 128'(32'hDEADBEEF));
    check("no_dm_traffic", 128'({rd_cnt, wr_cnt}), {64'h0, 32'd1, 32'd0});

    // Dirty eviction with the write request held 5 cycles
    hold_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fork
      do_req(32'h204, 1'b0, 1'b1, '0, rdata, missed);
      begin
        @(posedge clk);
        repeat (5) begin
          @(negedge clk);
          #3;
          check("wb_hold_ctrl", 128'({dm_is_input_valid, dm_write, dm_read, is_ready}), 128'(4'b1100));
          check("wb_hold_addr", 128'(dm_addr), 128'(32'h10));
          check("wb_hold_word1", 128'(dm_din[63:32]), 128'(32'hDEADBEEF));
          check("wb_hold_count", 128'(wr_cnt), '0);
        end
        hold_ready = 1'b0;
      end
    join
    check("evict_missed", 128'(missed), 128'(1'b1));
    check("evict_wr_once", 128'(wr_cnt), 128'(1));
    check("evict_wr_addr", 128'(last_wr_addr), 128'(32'h10));
    check("evict_wr_word1", 128'(last_wr_line[63:32]), 128'(32'hDEADBEEF));
    check("evict_rd_addr", 128'(last_rd_addr), 128'(32'h20));
    check("evict_data", 128'(rdata), 128'(32'h0081FF7E));

    // Read+write together behaves as a store
    do_req(32'h208, 1'b1, 1'b1, 32'h12345678, rdata, missed);
    do_req(32'h208, 1'b0, 1'b1, '0, rdata, missed);
    check("rw_as_store", 128'(rdata), 128'(32'h12345678));
    check("directed_counts", 128'({hit_count, miss_count}), 128'({32'(exp_hits), 32'(exp_misses)}));

    // Make set 0 clean again, then reset while a refill is outstanding
    do_req(32'h100, 1'b0, 1'b1, '0, rdata, missed);
    mem_delay = 6;
    is_input_valid = 1'b1;
    addr = 32'h300;
    mem_read = 1'b1;
    cyc = 0;
    while (rd_cnt < 4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("alloc_wait_reached", 128'(rd_cnt), 128'(4));
    @(negedge clk);
    reset = 1'b0;
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    #1;
    check("midreset_ready", 128'(is_ready), 128'(1'b1));
    check("midreset_dm", 128'({dm_is_input_valid, dm_read, dm_write, dm_addr}), '0);
    check("midreset_counters", 128'({hit_count, miss_count}), '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    mem_delay = 2;
    @(negedge clk);
    check("post_reset_idle", 128'(is_ready), 128'(1'b1));
    do_req(32'h100, 1'b0, 1'b1, '0, rdata, missed);
    check("post_reset_miss", 128'(missed), 128'(1'b1));
    check("post_reset_miss_count", 128'(miss_count), 128'(32'd1));
    check("post_reset_data", 128'(rdata), 128'(32'h0040FFBF));

    // Randomized mixed stream
    rand_stall = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int          op;
      a = {($urandom_range(0, 1) == 1) ? 22'h3FFFFF : 22'h0, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      do_req(a, op != 0, op != 1, $urandom, rdata, missed);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_stall = 1'b0;
    check("final_hits", 128'(hit_count), 128'(32'(exp_hits)));
    check("final_misses", 128'(miss_count), 128'(32'(exp_misses)));
    check("final_sum", 128'(hit_count + miss_count), 128'(32'(exp_hits + exp_misses)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters SHALL be: LINE_SIZE, 16, bytes per line (matches memory block width); NUM_SETS, 16, direct-mapped sets; WORD, 32, CPU word width.
REQ-002 Ports SHALL be (name dir width meaning): clk in 1 clock; reset in 1 asynchronous, active-low reset (0 = asserted).
REQ-003 CPU side: is_input_valid in 1 request present; addr in 32 byte address; mem_read in 1 load; mem_write in 1 store; din in 32 store data.
REQ-004 CPU side: is_ready out 1 cache idle; is_output_valid out 1 load data valid; dout out 32 load data; is_hit out 1 request hits this cycle.
REQ-005 Memory side: dm_is_input_valid out 1; dm_addr out 32 block address; dm_read out 1; dm_write out 1; dm_din out 128 line to write.
REQ-006 Memory side: dm_is_output_valid in 1; dm_dout in 128 returned line; dm_ready in 1 memory idle.
REQ-007 Statistics: hit_count out 32; miss_count out 32.

Function
REQ-008 Address split SHALL be tag = addr[31:8], index = addr[7:4], word = addr[3:2]; addr[1:0] ignored.
REQ-009 Each set SHALL hold valid bit, dirty bit, 24-bit tag, 128-bit line; policy write-back, write-allocate.
REQ-010 FSM states SHALL be IDLE, WB_REQ, WB_WAIT, ALLOC_REQ, ALLOC_WAIT; is_ready = (state == IDLE).
REQ-011 In IDLE, is_hit = is_input_valid & (mem_read|mem_write) & valid[index] & tag match, combinationally.
REQ-012 Load hit: is_output_valid = 1 and dout = selected word in the same cycle; zero-cycle latency.
REQ-013 Store hit: the selected word SHALL be updated and dirty set at the next posedge clk; other words unchanged.
REQ-014 Miss in IDLE: to WB_REQ if valid & dirty, else to ALLOC_REQ; miss_count increments once per miss.
REQ-015 hit_count SHALL increment only on IDLE hits; a request that misses, refills, then hits counts one miss and one hit.
REQ-016 WB_REQ: dm_is_input_valid = dm_write = 1, dm_addr = {4'b0, stored tag, index}, dm_din = line; to WB_WAIT at the first edge where dm_ready = 1.
REQ-017 WB_WAIT: drive no request; to ALLOC_REQ at the first edge where dm_ready = 1.
REQ-018 ALLOC_REQ: dm_is_input_valid = dm_read = 1, dm_addr = {4'b0, addr[31:4]}; to ALLOC_WAIT at the first edge where dm_ready = 1.
REQ-019 ALLOC_WAIT: on dm_is_output_valid, write dm_dout into the line, set valid, clear dirty and store tag, then go to IDLE.
REQ-020 After refill the held request SHALL complete as an IDLE hit; the CPU holds addr/din/op stable until is_hit = 1.
REQ-021 Outside IDLE: is_output_valid = 0, is_hit = 0, dout = 0; CPU inputs are ignored.
REQ-022 dm_read and dm_write SHALL never be asserted together, and no request is driven in IDLE, WB_WAIT or ALLOC_WAIT.
REQ-023 A request with both mem_read and mem_write set SHALL be treated as a store.
REQ-024 hit_count and miss_count SHALL wrap modulo 2^32.

Reset
REQ-025 While reset = 0: state = IDLE; all valid and dirty bits = 0; counters = 0; every dm_* output = 0; is_output_valid = 0; dout = 0; is_hit = 0.
REQ-026 Reset asserted mid-WB or mid-ALLOC SHALL abandon the transaction without any partial line update; tag and data arrays need not clear.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the field widths (tag 24, index 4, offset 4) and LINE_SIZE.
REQ-028 The tag/valid/dirty/data storage SHALL be one sub-module, cache_array (combinational read, synchronous write); FSM and counters stay in data_cache.

Verification
REQ-029 Cold load 0x0000_0100 -> one ALLOC read, dm_addr = 0x10, miss_count = 1, then a hit returning word 0 of the line.
REQ-030 Store 0xDEADBEEF to 0x104, then load 0x104 -> both hits, dout = 0xDEADBEEF, no dm traffic.
REQ-031 Load 0x0000_0204 after a dirty 0x104 (same index 0) -> WB write, dm_addr = 0x10, dm_din word 1 = 0xDEADBEEF, then ALLOC read at dm_addr = 0x20.
REQ-032 Hold dm_ready = 0 for 5 cycles in WB_REQ -> request held stable, no state change, single write issued.
REQ-033 Reset pulse in ALLOC_WAIT -> IDLE next cycle, line 0 invalid, and a following load to 0x100 misses.
REQ-034 Mixed stream against the memory model (DELAY = 2) -> every dout matches the golden model and hit_count + miss_count equals accepted requests plus misses.
